// File: rtl/heartbeat_monitor.sv
// Heartbeat receive checker: synchronises a peer heartbeat, measures edge intervals, reports alive/fault.
// Build option HB_MON_STICKY_FAULT_EN: a fault latches until iFaultClr (or reset) instead of self-recovering.
//
//  state     | meaning
//  ST_ACQ    | collecting consecutive good intervals, not yet alive
//  ST_LOCKED | source alive and in tolerance
//  ST_FAULT  | fault reported, cause latched in oFaultCode

module heartbeat_monitor #(
    parameter  int HB_DIV     = 249999,
    parameter  int TOL        = 25000,
    parameter  int LOCK_EDGES = 4,
    localparam int CNT_W      = $clog2(HB_DIV + 1 + TOL + 2)
) (
    input  logic             iClk,
    input  logic             iRst_n,
    input  logic             iHeartBeat,
    input  logic             iFaultClr,
    output logic             oEdgePulse,
    output logic             oAlive,
    output logic             oFault,
    output logic [1:0]       oFaultCode,
    output logic [CNT_W-1:0] oLastInterval
);

    localparam int P_NOM = HB_DIV + 1;
    localparam int GW    = $clog2(LOCK_EDGES + 1);

    localparam logic [CNT_W-1:0] LIM_C  = CNT_W'(P_NOM + TOL + 1);
    localparam logic [CNT_W-1:0] LO_C   = CNT_W'(P_NOM - TOL);
    localparam logic [CNT_W-1:0] HI_C   = CNT_W'(P_NOM + TOL);
    localparam logic [GW-1:0]    LOCK_C = GW'(LOCK_EDGES);

    localparam logic [1:0] ST_ACQ    = 2'd0;
    localparam logic [1:0] ST_LOCKED = 2'd1;
    localparam logic [1:0] ST_FAULT  = 2'd2;

    localparam logic [1:0] CODE_NONE = 2'b00;
    localparam logic [1:0] CODE_FAST = 2'b01;
    localparam logic [1:0] CODE_SLOW = 2'b10;

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             prev_q, prev_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tmo_q, tmo_d;
    logic             first_q, first_d;
    logic [GW-1:0]    good_q, good_d;
    logic [1:0]       state_q, state_d;
    logic             edge_pulse_q, edge_pulse_d;
    logic             alive_q, alive_d;
    logic             fault_q, fault_d;
    logic [1:0]       code_q, code_d;
    logic [CNT_W-1:0] last_q, last_d;

    logic hb_edge;
    logic clr;
    logic tmo_hit;
    logic eval;
    logic ev_good;
    logic ev_fast;
    logic ev_slow;

`ifdef HB_MON_STICKY_FAULT_EN
    assign clr = iFaultClr && (state_q == ST_FAULT);
`else
    logic unused_fault_clr;
    assign unused_fault_clr = iFaultClr;
    assign clr = 1'b0;
`endif

    always_comb begin
        sync1_d = iHeartBeat;
        sync2_d = sync1_q;
        prev_d  = sync2_q;
        hb_edge = sync2_q ^ prev_q;

        // tmo_q keeps a held-at-limit counter from reporting the same loss every cycle
        tmo_hit = !hb_edge && (cnt_q == LIM_C) && !tmo_q;
        eval    = hb_edge && !first_q && !clr;
        ev_good = eval && (cnt_q >= LO_C) && (cnt_q <= HI_C);
        ev_fast = eval && (cnt_q < LO_C);
        ev_slow = (eval && (cnt_q > HI_C)) || (tmo_hit && !clr);

        if (hb_edge)
            cnt_d = CNT_W'(1);
        else if (cnt_q == LIM_C)
            cnt_d = cnt_q;
        else
            cnt_d = cnt_q + 1'b1;

        if (hb_edge)
            tmo_d = 1'b0;
        else
            tmo_d = tmo_q | tmo_hit;

        if (clr)
            first_d = !hb_edge;
        else if (hb_edge)
            first_d = 1'b0;
        else
            first_d = first_q;

        last_d = eval ? cnt_q : last_q;

        if (clr || ev_fast || ev_slow)
            good_d = '0;
        else if (ev_good && (good_q != LOCK_C))
            good_d = good_q + 1'b1;
        else
            good_d = good_q;

        state_d = state_q;
        code_d  = code_q;
        case (state_q)
            ST_ACQ: begin
                if (ev_slow) begin
                    state_d = ST_FAULT;
                    code_d  = CODE_SLOW;
                end else if (ev_good && (good_d == LOCK_C)) begin
                    state_d = ST_LOCKED;
                end
            end
            ST_LOCKED: begin
                if (ev_fast) begin
                    state_d = ST_FAULT;
                    code_d  = CODE_FAST;
                end else if (ev_slow) begin
                    state_d = ST_FAULT;
                    code_d  = CODE_SLOW;
                end
            end
            ST_FAULT: begin
                if (clr) begin
                    state_d = ST_ACQ;
                    code_d  = CODE_NONE;
`ifndef HB_MON_STICKY_FAULT_EN
                end else if (ev_good && (good_d == LOCK_C)) begin
                    state_d = ST_LOCKED;
                    code_d  = CODE_NONE;
`endif
                end
            end
            default: begin
                state_d = ST_ACQ;
                code_d  = CODE_NONE;
            end
        endcase

        edge_pulse_d = hb_edge;
        alive_d      = (state_d == ST_LOCKED);
        fault_d      = (state_d == ST_FAULT);
    end

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            sync1_q      <= 1'b0;
            sync2_q      <= 1'b0;
            prev_q       <= 1'b0;
            cnt_q        <= '0;
            tmo_q        <= 1'b0;
            first_q      <= 1'b1;
            good_q       <= '0;
            state_q      <= ST_ACQ;
            edge_pulse_q <= 1'b0;
            alive_q      <= 1'b0;
            fault_q      <= 1'b0;
            code_q       <= CODE_NONE;
            last_q       <= '0;
        end else begin
            sync1_q      <= sync1_d;
            sync2_q      <= sync2_d;
            prev_q       <= prev_d;
            cnt_q        <= cnt_d;
            tmo_q        <= tmo_d;
            first_q      <= first_d;
            good_q       <= good_d;
            state_q      <= state_d;
            edge_pulse_q <= edge_pulse_d;
            alive_q      <= alive_d;
            fault_q      <= fault_d;
            code_q       <= code_d;
            last_q       <= last_d;
        end
    end

    assign oEdgePulse    = edge_pulse_q;
    assign oAlive        = alive_q;
    assign oFault        = fault_q;
    assign oFaultCode    = code_q;
    assign oLastInterval = last_q;

endmodule

// File: tb/tb_heartbeat_monitor.sv
// Bench for heartbeat_monitor (P_NOM=10, TOL=2, LOCK_EDGES=3, LIM=13); honours HB_MON_STICKY_FAULT_EN.
module tb_heartbeat_monitor;

    localparam int HB_DIV = 9;
    localparam int TOL    = 2;
    localparam int LOCK   = 3;
    localparam int P_NOM  = HB_DIV + 1;
    localparam int LIM    = P_NOM + TOL + 1;
`ifdef HB_MON_STICKY_FAULT_EN
    localparam bit STICKY = 1'b1;
`else
    localparam bit STICKY = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       hb = 1'b0;
    logic       fclr = 1'b0;
    logic       edge_pulse;
    logic       alive;
    logic       fault;
    logic [1:0] code;
    logic [3:0] last_iv;

    heartbeat_monitor #(.HB_DIV(HB_DIV), .TOL(TOL), .LOCK_EDGES(LOCK)) dut (
        .iClk(clk), .iRst_n(rst_n), .iHeartBeat(hb), .iFaultClr(fclr),
        .oEdgePulse(edge_pulse), .oAlive(alive), .oFault(fault),
        .oFaultCode(code), .oLastInterval(last_iv)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // reference model: 0 = acquiring, 1 = alive, 2 = faulted
    int m_mode, m_good, m_code, m_last, last_gap;
    bit m_first;

    function automatic void m_reset();
        m_mode = 0; m_good = 0; m_code = 0; m_last = 0; last_gap = 0; m_first = 1'b1;
    endfunction

    // cls: 0 good, 1 fast, 2 slow
    function automatic void m_apply(int cls);
        if (cls == 0) begin
            m_good = (m_good < LOCK) ? m_good + 1 : LOCK;
            if (m_good == LOCK && (m_mode == 0 || (m_mode == 2 && !STICKY))) begin
                m_mode = 1; m_code = 0;
            end
        end else begin
            m_good = 0;
            if (cls == 1 && m_mode == 1) begin m_mode = 2; m_code = 1; end
            if (cls == 2 && m_mode != 2) begin m_mode = 2; m_code = 2; end
        end
    endfunction

    function automatic void m_edge();
        int i;
        if (m_first) begin
            m_first = 1'b0;
            return;
        end
        i = (last_gap > LIM) ? LIM : last_gap;
        m_last = i;
        if (i < P_NOM - TOL)      m_apply(1);
        else if (i > P_NOM + TOL) m_apply(2);
        else                      m_apply(0);
    endfunction

    function automatic void m_clear();
        if (STICKY && m_mode == 2) begin
            m_mode = 0; m_code = 0; m_good = 0; m_first = 1'b1;
        end
    endfunction

    task automatic chk(input string tag);
        logic       e_alive, e_fault;
        logic [1:0] e_code;
        logic [3:0] e_last;
        e_alive = (m_mode == 1);
        e_fault = (m_mode == 2);
        e_code  = 2'(m_code);
        e_last  = 4'(m_last);
        tests += 4;
        assert (alive === e_alive) else begin
            fails++; $error("FAIL %s alive: observed %b expected %b", tag, alive, e_alive);
        end
        assert (fault === e_fault) else begin
            fails++; $error("FAIL %s fault: observed %b expected %b", tag, fault, e_fault);
        end
        assert (code === e_code) else begin
            fails++; $error("FAIL %s code: observed %b expected %b", tag, code, e_code);
        end
        assert (last_iv === e_last) else begin
            fails++; $error("FAIL %s last_interval: observed %0d expected %0d", tag, last_iv, e_last);
        end
    endtask

    task automatic chk_zero(input string tag);
        tests++;
        assert ({edge_pulse, alive, fault, code, last_iv} === 9'd0) else begin
            fails++;
            $error("FAIL %s outputs: observed %b expected 0", tag, {edge_pulse, alive, fault, code, last_iv});
        end
    endtask

    // toggle the heartbeat, then hold it for n clocks; clr_k > 0 pulses iFaultClr in that clock
    task automatic step(input int n, input int clr_k);
        int  pulses;
        bit  p3;
        bit  tmo_done;
        pulses = 0; p3 = 1'b0; tmo_done = 1'b0;
        hb = ~hb;
        m_edge();
        for (int k = 1; k <= n; k++) begin
            if (k == clr_k) fclr = 1'b1;
            @(negedge clk);
            if (edge_pulse) begin
                pulses++;
                if (k == 3) p3 = 1'b1;
            end
            if (k == 3) chk("edge");
            if (k == clr_k) begin
                fclr = 1'b0;
                m_clear();
                chk("fault_clr");
            end
            if (n > LIM && k == LIM + 3) begin
                m_timeout_apply();
                tmo_done = 1'b1;
                chk("timeout");
            end
        end
        if (n > LIM && !tmo_done) m_timeout_apply();
        last_gap = n;
        tests += 2;
        assert (pulses === 1) else begin
            fails++; $error("FAIL edge_pulse_count: observed %0d expected 1", pulses);
        end
        assert (p3 === 1'b1) else begin
            fails++; $error("FAIL edge_pulse_latency: observed %b expected 1", p3);
        end
    endtask

    function automatic void m_timeout_apply();
        m_apply(2);
    endfunction

    initial begin
        int n;
        m_reset();
        repeat (3) @(negedge clk);
        chk_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // steady 10-clock toggling: alive after the 4th edge
        for (int i = 0; i < 6; i++) step(10, 0);
        // tolerance boundaries 8 and 12, then 7 is too fast
        step(8, 0);
        step(12, 0);
        step(7, 0);
        step(10, 6);
        // recovery (or held fault with a clear pulse in the sticky build)
        for (int i = 0; i < 5; i++) step(10, 0);
        // lost heartbeat from LOCKED: timeout, then the late edge is slow
        step(20, 0);
        step(10, 6);
        for (int i = 0; i < 5; i++) step(10, 0);
        // interval exactly at the limit
        step(13, 0);
        step(10, 6);
        for (int i = 0; i < 5; i++) step(10, 0);

        // asynchronous reset while locked
        #2 rst_n = 1'b0;
        #1 chk_zero("async_reset");
        hb = 1'b0;
        m_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 5; i++) step(10, 0);

        // randomized intervals, mostly in tolerance
        for (int i = 0; i < 80; i++) begin
            if ($urandom_range(0, 9) < 6) n = $urandom_range(8, 12);
            else                          n = $urandom_range(5, 17);
            step(n, (n >= 7 && $urandom_range(0, 4) == 0) ? 6 : 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
